// File: rtl/ttfir_seq.sv
// Time-multiplexed multi-channel FIR: one shared multiplier walks the taps of
// the selected channel, then rounds, shifts and saturates the accumulated sum.
module ttfir_seq #(
    parameter int N_TAPS  = 4,
    parameter int BW_IN   = 4,
    parameter int BW_COEF = 4,
    parameter int BW_OUT  = 8,
    parameter int N_CH    = 2,
    parameter int SHIFT   = 0,
    localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [BW_IN-1:0]   x_in,
    input  logic        [CW-1:0]      ch_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      coef_we,
    input  logic signed [BW_COEF-1:0] coef_in,
    output logic signed [BW_OUT-1:0]  y_out,
    output logic        [CW-1:0]      ch_out,
    output logic                      out_valid
);

    localparam int KW    = $clog2(N_TAPS);
    localparam int PW    = BW_IN + BW_COEF;
    localparam int ACCW  = PW + KW;
    localparam int ROUND = (2 ** SHIFT) / 2;
    localparam int YMAX  = (2 ** (BW_OUT - 1)) - 1;
    localparam int YMIN  = -(2 ** (BW_OUT - 1));
    localparam logic [KW-1:0] KLAST = KW'(N_TAPS - 1);
    localparam logic [CW:0]   NCH_L = (CW + 1)'(N_CH);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                     state_q, state_d;
    logic        [KW-1:0]       k_q, k_d;
    logic        [CW-1:0]       chSel_q, chSel_d;
    logic signed [ACCW-1:0]     acc_q, acc_d;
    logic signed [BW_OUT-1:0]   y_q, y_d;
    logic        [CW-1:0]       chOut_q, chOut_d;
    logic                       outValid_q, outValid_d;
    logic                       accept, coefWrite;

    logic signed [BW_COEF-1:0]  coef_q [N_TAPS];
    logic signed [BW_IN-1:0]    dly_q  [N_CH][N_TAPS];

    logic signed [BW_COEF-1:0]  coefSel;
    logic signed [BW_IN-1:0]    dlySel;
    logic signed [PW-1:0]       prod;
    logic signed [31:0]         accExt, rnd, shifted;
    logic signed [BW_OUT-1:0]   satVal;

    assign in_ready  = (state_q == IDLE) && !coef_we;
    assign y_out     = y_q;
    assign ch_out    = chOut_q;
    assign out_valid = outValid_q;

    assign coefSel = coef_q[k_q];
    assign dlySel  = dly_q[chSel_q][k_q];
    assign prod    = $signed({{BW_IN{coefSel[BW_COEF-1]}}, coefSel})
                   * $signed({{BW_COEF{dlySel[BW_IN-1]}}, dlySel});

    // Round-half-up before the arithmetic shift, then clamp to the output range.
    always_comb begin
        accExt  = {{(32 - ACCW){acc_q[ACCW-1]}}, acc_q};
        rnd     = accExt + ROUND;
        shifted = rnd >>> SHIFT;
        satVal  = shifted[BW_OUT-1:0];
        if (shifted > YMAX) begin
            satVal = BW_OUT'(YMAX);
        end else if (shifted < YMIN) begin
            satVal = BW_OUT'(YMIN);
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        chSel_d    = chSel_q;
        acc_d      = acc_q;
        y_d        = y_q;
        chOut_d    = chOut_q;
        outValid_d = 1'b0;
        accept     = 1'b0;
        coefWrite  = 1'b0;
        case (state_q)
            IDLE: begin
                if (coef_we) begin
                    coefWrite = 1'b1;
                end else if (in_valid && ({1'b0, ch_in} < NCH_L)) begin
                    accept  = 1'b1;
                    chSel_d = ch_in;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + {{KW{prod[PW-1]}}, prod};
                k_d   = k_q + KW'(1);
                if (k_q == KLAST) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                y_d        = satVal;
                chOut_d    = chSel_q;
                outValid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            chSel_q    <= '0;
            acc_q      <= '0;
            y_q        <= '0;
            chOut_q    <= '0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            chSel_q    <= chSel_d;
            acc_q      <= acc_d;
            y_q        <= y_d;
            chOut_q    <= chOut_d;
            outValid_q <= outValid_d;
        end
    end

    // Coefficients shift toward index 0 so the k-th value written lands in coef[k].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_TAPS; i++) begin
                coef_q[i] <= '0;
            end
            for (int c = 0; c < N_CH; c++) begin
                for (int i = 0; i < N_TAPS; i++) begin
                    dly_q[c][i] <= '0;
                end
            end
        end else begin
            if (coefWrite) begin
                for (int i = 0; i < N_TAPS - 1; i++) begin
                    coef_q[i] <= coef_q[i+1];
                end
                coef_q[N_TAPS-1] <= coef_in;
            end
            if (accept) begin
                for (int i = N_TAPS - 1; i > 0; i--) begin
                    dly_q[ch_in][i] <= dly_q[ch_in][i-1];
                end
                dly_q[ch_in][0] <= x_in;
            end
        end
    end

endmodule

// File: tb/tb_ttfir_seq.sv
// Randomized and directed bench for ttfir_seq; two instances (SHIFT 0 and 2)
// share stimulus and are compared against an arithmetic reference model.
module tb_ttfir_seq;

   localparam int NT = 4;
   localparam int NC = 2;

   logic              clock;
   logic              reset;
   logic signed [3:0] xIn;
   logic [0:0]        chIn;
   logic              inValid;
   logic              coefWe;
   logic signed [3:0] coefIn;
   logic              rdy0, rdy2, ov0, ov2;
   logic signed [7:0] y0, y2;
   logic [0:0]        cho0, cho2;

   int numChecks = 0;
   int numFails  = 0;
   int coefM [NT];
   int hist  [NC][NT];
   int lastY0, lastY2, lastCh;

   ttfir_seq #(.SHIFT(0)) dut0 (
      .clk(clock), .rst(reset), .x_in(xIn), .ch_in(chIn), .in_valid(inValid),
      .in_ready(rdy0), .coef_we(coefWe), .coef_in(coefIn), .y_out(y0),
      .ch_out(cho0), .out_valid(ov0)
   );

   ttfir_seq #(.SHIFT(2)) dut2 (
      .clk(clock), .rst(reset), .x_in(xIn), .ch_in(chIn), .in_valid(inValid),
      .in_ready(rdy2), .coef_we(coefWe), .coef_in(coefIn), .y_out(y2),
      .ch_out(cho2), .out_valid(ov2)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      numChecks++;
      if (observed !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reference output: dot product of coefficients and history, then round, shift, clamp.
   function automatic int modelY(input int ch, input int sh);
      int acc;
      acc = 0;
      for (int k = 0; k < NT; k++) acc += coefM[k] * hist[ch][k];
      acc = (acc + (2 ** sh) / 2) >>> sh;
      if (acc > 127) acc = 127;
      if (acc < -128) acc = -128;
      return acc;
   endfunction

   // Pulses reset low for two cycles and clears the model state to match.
   task automatic doReset();
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < NT; k++) begin
         coefM[k] = 0;
         for (int c = 0; c < NC; c++) hist[c][k] = 0;
      end
   endtask

   // One coefficient write; model shifts its array the same way the block's is defined.
   task automatic writeCoef(input int v);
      @(negedge clock);
      coefWe = 1'b1;
      coefIn = 4'(v);
      @(negedge clock);
      coefWe = 1'b0;
      for (int k = 0; k < NT - 1; k++) coefM[k] = coefM[k+1];
      coefM[NT-1] = v;
   endtask

   task automatic loadCoefs(input int a, input int b, input int c, input int d);
      writeCoef(a);
      writeCoef(b);
      writeCoef(c);
      writeCoef(d);
   endtask

   // Offers one sample, waits (bounded) for the result and checks latency and values.
   task automatic applyStimulus(input int ch, input int x);
      int n;
      @(negedge clock);
      checkOutput("in_ready", int'(rdy0), 1);
      inValid = 1'b1;
      xIn     = 4'(x);
      chIn    = 1'(ch);
      @(posedge clock);
      #1 inValid = 1'b0;
      for (int k = NT - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
      hist[ch][0] = x;
      n = 0;
      while (n < 20) begin
         @(posedge clock);
         #1 n++;
         if (ov0) break;
      end
      checkOutput("latency", n, NT + 1);
      checkOutput("ov_shift2", int'(ov2), 1);
      lastY0 = int'(y0);
      lastY2 = int'(y2);
      lastCh = int'(cho0);
      checkOutput("y_shift0", lastY0, modelY(ch, 0));
      checkOutput("y_shift2", lastY2, modelY(ch, 2));
      checkOutput("ch_out", lastCh, ch);
      checkOutput("ch_out2", int'(cho2), ch);
      @(posedge clock);
      #1;
      checkOutput("ov_pulse", int'(ov0), 0);
      checkOutput("y_hold", int'(y0), lastY0);
   endtask

   initial begin
      int seen;
      reset   = 1'b1;
      xIn     = '0;
      chIn    = '0;
      inValid = 1'b0;
      coefWe  = 1'b0;
      coefIn  = '0;
      doReset();
      #1;
      checkOutput("rst_ov", int'(ov0), 0);
      checkOutput("rst_y", int'(y0), 0);
      checkOutput("rst_ch", int'(cho0), 0);
      checkOutput("rst_ready", int'(rdy0), 1);

      $display("[TB] zero coefficients after reset");
      applyStimulus(0, 5);
      checkOutput("zero_coef_y", lastY0, 0);

      $display("[TB] impulse response");
      doReset();
      loadCoefs(1, 2, 3, 4);
      applyStimulus(0, 1);
      checkOutput("imp0", lastY0, 1);
      applyStimulus(0, 0);
      checkOutput("imp1", lastY0, 2);
      applyStimulus(0, 0);
      checkOutput("imp2", lastY0, 3);
      applyStimulus(0, 0);
      checkOutput("imp3", lastY0, 4);

      $display("[TB] channel independence");
      doReset();
      loadCoefs(1, 2, 3, 4);
      applyStimulus(0, 1);
      checkOutput("chA", lastY0, 1);
      applyStimulus(1, 7);
      checkOutput("chB", lastY0, 7);
      checkOutput("chB_ch", lastCh, 1);
      applyStimulus(0, 0);
      checkOutput("chC", lastY0, 2);

      $display("[TB] saturation");
      doReset();
      loadCoefs(7, 7, 7, 7);
      applyStimulus(0, 7);
      checkOutput("sat0", lastY0, 49);
      applyStimulus(0, 7);
      checkOutput("sat1", lastY0, 98);
      applyStimulus(0, 7);
      checkOutput("sat2", lastY0, 127);
      applyStimulus(0, 7);
      checkOutput("sat3", lastY0, 127);

      $display("[TB] rounding shift");
      doReset();
      loadCoefs(1, 0, 0, 0);
      applyStimulus(0, 6);
      checkOutput("shift_pos", lastY2, 2);
      applyStimulus(0, -6);
      checkOutput("shift_neg", lastY2, -1);

      $display("[TB] coefficient write wins over sample");
      @(negedge clock);
      coefWe  = 1'b1;
      coefIn  = 4'(3);
      inValid = 1'b1;
      xIn     = 4'(5);
      chIn    = 1'(0);
      #1 checkOutput("ready_during_we", int'(rdy0), 0);
      @(negedge clock);
      coefWe  = 1'b0;
      inValid = 1'b0;
      for (int k = 0; k < NT - 1; k++) coefM[k] = coefM[k+1];
      coefM[NT-1] = 3;
      seen = 0;
      repeat (8) begin
         @(posedge clock);
         #1 if (ov0) seen = 1;
      end
      checkOutput("no_accept_with_we", seen, 0);
      applyStimulus(0, 2);

      $display("[TB] reset during MAC");
      doReset();
      loadCoefs(1, 1, 1, 1);
      @(negedge clock);
      inValid = 1'b1;
      xIn     = 4'(5);
      chIn    = 1'(0);
      @(posedge clock);
      #1 inValid = 1'b0;
      repeat (2) @(posedge clock);
      #2 reset = 1'b0;
      seen = 0;
      repeat (2) begin
         @(posedge clock);
         #1 if (ov0) seen = 1;
      end
      @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < NT; k++) begin
         coefM[k] = 0;
         for (int c = 0; c < NC; c++) hist[c][k] = 0;
      end
      repeat (8) begin
         @(posedge clock);
         #1 if (ov0) seen = 1;
      end
      checkOutput("abort_no_ov", seen, 0);
      checkOutput("abort_ready", int'(rdy0), 1);
      applyStimulus(0, 3);
      checkOutput("abort_y", lastY0, 0);

      $display("[TB] randomized traffic");
      doReset();
      for (int r = 0; r < 6; r++) begin
         loadCoefs(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                   int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
         for (int s = 0; s < 8; s++) begin
            applyStimulus(int'($urandom_range(0, NC - 1)), int'($urandom_range(0, 15)) - 8);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

   // Absolute time limit so a stuck design still produces a summary.
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: observed no completion, expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
